apr_fm_parity_check: RTL and testbench
======================================

Name: apr_fm_parity_check

Overview:
- Downstream consumer of the EDP slices' fast-memory parity outputs (edp_fm_parity_XXtoYY_h).
- XORs the six slice parities into one word parity and stores it on every FM write, in a 128x1 shadow RAM indexed by block/AC.
- On every FM read, compares the recomputed parity with the stored bit.
- On mismatch: raises a sticky APR error, captures the failing address, counts errors.

Parameters:
- FM_ADR_W, 7, FM address width: block[2:0] concatenated with AC[3:0].
- SLICES, 6, number of EDP six-bit slices whose parity is combined.
- CNT_W, 4, width of the saturating error counter.

Ports:
- clk_apr_h  input  1  APR clock; all state updates on its rising edge.
- mr_reset_h  input  1  master reset; synchronous, active-high.
- apr_fm_block_h  input  3  current FM block.
- apr_fm_adr_h  input  4  current AC address within block.
- con_fm_write_h  input  1  FM write this cycle; slice parities describe the write data.
- con_fm_read_h  input  1  FM read issued this cycle; data (and slice parities) valid next cycle.
- edp_fm_parity_h  input  SLICES  slice parities, bit 0 = 00to05 … bit 5 = 30to35.
- con_fm_par_chk_en_h  input  1  enables comparison; stores happen regardless.
- apr_fm_par_err_clr_h  input  1  clears sticky error and captured address.
- apr_fm_par_err_h  output  1  sticky parity-error flag.
- apr_fm_par_err_int_h  output  1  one-cycle pulse when the sticky flag sets.
- apr_fm_err_adr_h  output  FM_ADR_W  address of first error since last clear.
- apr_fm_par_err_cnt_h  output  CNT_W  saturating count of detected errors.

Behaviour:
- Clock and reset: one clock (clk_apr_h); reset mr_reset_h is synchronous, active-high.
- Reset values:
  - all outputs 0;
  - all 128 valid bits 0;
  - read pipeline stage invalid;
  - shadow parity bits are don't-care.
- Word parity: wp = XOR of edp_fm_parity_h[SLICES-1:0].
- Write, cycle N, con_fm_write_h=1:
  - at edge ending N, store wp at adr={block,ac};
  - set valid[adr].
- Read, cycle N, con_fm_read_h=1 and write=0:
  - at edge ending N, register adr, stored bit, valid bit and chk_en into stage S1;
  - in cycle N+1, compare wp against the S1 stored bit;
  - mismatch = S1 valid & entry valid & chk_en & (wp != stored);
  - error outputs update at edge ending N+1, visible in cycle N+2.
- Write and read in the same cycle: write wins, no check is launched.
- Back-to-back reads: fully pipelined, one check per cycle.
- Write to address A in cycle N+1 while a read of A is in S1: the check uses the stored bit captured at N (old value).
- On mismatch:
  - if sticky=0: set sticky, capture adr, pulse int for one cycle;
  - if sticky=1: address is held, no int pulse;
  - counter increments, saturating at all-ones.
- Clear asserted:
  - sticky and err_adr go to 0; counter also zeroed;
  - if a mismatch occurs in the same cycle, the new error wins: sticky=1, new adr captured, int pulses, counter=1.
- Reading an unwritten entry (valid=0) never flags.
- Reset mid-operation discards the S1 stage; no error may be reported for a read launched before reset.

Optional Feature:
- Macro: FM_PAR_INJECT_EN.
- Defined:
  - adds input diag_fm_par_inject_h (1 bit);
  - while high, stored parity on writes is ~wp, creating a known-bad entry for diagnostics.
- Undefined:
  - port absent;
  - stored parity is always wp.

Decomposition:
- Package apr_fm_pkg:
  - fm_adr_t (7 bits) and FM_WORDS=128;
  - SLICES and CNT_W defaults;
  - function fm_word_parity(slices).
- Sub-module fm_par_ram:
  - 128x1 parity storage plus valid vector;
  - synchronous write, combinational read, synchronous valid clear on reset;
  - instantiated once.

Test Plan:
1. Write blk2/ac5 with parity=6'b000001, then read with same slices, chk_en=1 -> err stays 0, cnt=0.
2. Write blk2/ac5 with 6'b000001, then read with 6'b000011 -> err=1 and int pulse in cycle N+2, err_adr=7'h25, cnt=1.
3. Second mismatch at blk0/ac3 after case 2 -> err_adr stays 7'h25, no int pulse, cnt=2; 17 further errors -> cnt saturates at 4'hF.
4. Clear asserted in the same cycle as a mismatch on blk7/ac15 -> err=1, err_adr=7'h7F, cnt=1, int pulse.
5. Read of a never-written address after reset with mismatching slices -> no error; read launched, then reset next cycle -> no error.
6. With FM_PAR_INJECT_EN defined, write blk1/ac0 with inject=1, read with same slices -> error, err_adr=7'h10; with chk_en=0 -> no error.

Source files
------------

// File: rtl/apr_fm_pkg.sv
// apr_fm_pkg: shared types, defaults and word-parity helper for the APR fast-memory parity checker
package apr_fm_pkg;
  localparam int DEF_FM_ADR_W = 7;
  localparam int DEF_SLICES = 6;
  localparam int DEF_CNT_W = 4;
  localparam int FM_WORDS = 128;
  typedef logic [DEF_FM_ADR_W-1:0] fm_adr_t;
  function automatic logic fm_word_parity(input logic [31:0] slices);
    return ^slices;
  endfunction
endpackage

// File: rtl/fm_par_ram.sv
// fm_par_ram: 128x1 shadow parity store with per-entry valid bits
module fm_par_ram import apr_fm_pkg::*; (
  input  logic    clk,
  input  logic    rst,
  input  logic    we,
  input  fm_adr_t adr,
  input  logic    wbit,
  output logic    rbit,
  output logic    rvld
);
  logic [FM_WORDS-1:0] par;
  logic [FM_WORDS-1:0] vld;
  always_ff @(posedge clk) begin
    if (we) par[adr] <= wbit;
    if (rst) vld <= '0;
    else if (we) vld[adr] <= 1'b1;
  end
  assign rbit = par[adr];
  assign rvld = vld[adr];
endmodule

// File: rtl/apr_fm_parity_check.sv
// apr_fm_parity_check: stores FM word parity on writes and checks it on reads; FM_PAR_INJECT_EN adds a bad-parity inject input
module apr_fm_parity_check import apr_fm_pkg::*; #(
  parameter int FM_ADR_W = DEF_FM_ADR_W,
  parameter int SLICES = DEF_SLICES,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic                clk_apr_h,
  input  logic                mr_reset_h,
`ifdef FM_PAR_INJECT_EN
  input  logic                diag_fm_par_inject_h,
`endif
  input  logic [2:0]          apr_fm_block_h,
  input  logic [3:0]          apr_fm_adr_h,
  input  logic                con_fm_write_h,
  input  logic                con_fm_read_h,
  input  logic [SLICES-1:0]   edp_fm_parity_h,
  input  logic                con_fm_par_chk_en_h,
  input  logic                apr_fm_par_err_clr_h,
  output logic                apr_fm_par_err_h,
  output logic                apr_fm_par_err_int_h,
  output logic [FM_ADR_W-1:0] apr_fm_err_adr_h,
  output logic [CNT_W-1:0]    apr_fm_par_err_cnt_h
);
  logic wp, wbit, rbit, rvld, rd, mismatch, first;
  fm_adr_t adr;
  logic s1_vld, s1_bit, s1_ent, s1_en;
  fm_adr_t s1_adr;
  logic [CNT_W-1:0] cnt_nxt;
  assign adr = {apr_fm_block_h, apr_fm_adr_h};
  assign wp = fm_word_parity(32'(edp_fm_parity_h));
`ifdef FM_PAR_INJECT_EN
  assign wbit = wp ^ diag_fm_par_inject_h;
`else
  assign wbit = wp;
`endif
  fm_par_ram u_ram (
    .clk  (clk_apr_h),
    .rst  (mr_reset_h),
    .we   (con_fm_write_h),
    .adr  (adr),
    .wbit (wbit),
    .rbit (rbit),
    .rvld (rvld)
  );
  always_comb begin
    rd = con_fm_read_h & ~con_fm_write_h;
    mismatch = s1_vld & s1_ent & s1_en & (wp != s1_bit);
    first = mismatch & (~apr_fm_par_err_h | apr_fm_par_err_clr_h);
    cnt_nxt = apr_fm_par_err_clr_h ? CNT_W'(1) :
              (&apr_fm_par_err_cnt_h) ? apr_fm_par_err_cnt_h : apr_fm_par_err_cnt_h + CNT_W'(1);
  end
  always_ff @(posedge clk_apr_h) begin
    if (mr_reset_h) begin
      s1_vld <= 1'b0;
      s1_bit <= 1'b0;
      s1_ent <= 1'b0;
      s1_en <= 1'b0;
      s1_adr <= '0;
      apr_fm_par_err_h <= 1'b0;
      apr_fm_par_err_int_h <= 1'b0;
      apr_fm_err_adr_h <= '0;
      apr_fm_par_err_cnt_h <= '0;
    end else begin
      s1_vld <= rd;
      s1_bit <= rbit;
      s1_ent <= rvld;
      s1_en <= con_fm_par_chk_en_h;
      s1_adr <= adr;
      apr_fm_par_err_int_h <= first;
      if (mismatch) begin
        apr_fm_par_err_h <= 1'b1;
        apr_fm_par_err_cnt_h <= cnt_nxt;
        if (first) apr_fm_err_adr_h <= FM_ADR_W'(s1_adr);
      end else if (apr_fm_par_err_clr_h) begin
        apr_fm_par_err_h <= 1'b0;
        apr_fm_err_adr_h <= '0;
        apr_fm_par_err_cnt_h <= '0;
      end
    end
  end
endmodule

// File: tb/tb_apr_fm_parity_check.sv
// tb_apr_fm_parity_check: directed self-checking bench for apr_fm_parity_check
module tb_apr_fm_parity_check;
  logic clk = 0, rst = 1, inj = 0;
  logic [2:0] blk = 0;
  logic [3:0] ac = 0;
  logic wr_en = 0, rd_en = 0, en = 1, clr = 0;
  logic [5:0] par = 0;
  logic err, irq;
  logic [6:0] eadr;
  logic [3:0] cnt;
  int checks = 0, errors = 0;

  apr_fm_parity_check dut (
    .clk_apr_h            (clk),
    .mr_reset_h           (rst),
`ifdef FM_PAR_INJECT_EN
    .diag_fm_par_inject_h (inj),
`endif
    .apr_fm_block_h       (blk),
    .apr_fm_adr_h         (ac),
    .con_fm_write_h       (wr_en),
    .con_fm_read_h        (rd_en),
    .edp_fm_parity_h      (par),
    .con_fm_par_chk_en_h  (en),
    .apr_fm_par_err_clr_h (clr),
    .apr_fm_par_err_h     (err),
    .apr_fm_par_err_int_h (irq),
    .apr_fm_err_adr_h     (eadr),
    .apr_fm_par_err_cnt_h (cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int e, input int i, input int a, input int c);
    chk({tag, ".err"}, int'(err), e);
    chk({tag, ".int"}, int'(irq), i);
    chk({tag, ".adr"}, int'(eadr), a);
    chk({tag, ".cnt"}, int'(cnt), c);
  endtask

  task automatic wr(input logic [2:0] b, input logic [3:0] a, input logic [5:0] p);
    blk = b; ac = a; par = p; wr_en = 1;
    tick();
    wr_en = 0; par = 0;
  endtask

  task automatic rd(input logic [2:0] b, input logic [3:0] a, input logic [5:0] p, input logic e);
    blk = b; ac = a; en = e; rd_en = 1;
    tick();
    rd_en = 0; par = p;
    tick();
    par = 0; en = 1;
  endtask

  initial begin
    tick();
    tick();
    chk_all("reset", 0, 0, 0, 0);
    rst = 0;
    wr(2, 5, 6'b000001);
    rd(2, 5, 6'b000001, 1);
    chk_all("match", 0, 0, 0, 0);
    wr(2, 5, 6'b000001);
    rd(2, 5, 6'b000011, 1);
    chk_all("first_err", 1, 1, 'h25, 1);
    tick();
    chk("int_one_cycle", int'(irq), 0);
    wr(0, 3, 6'b000000);
    rd(0, 3, 6'b000001, 1);
    chk_all("second_err", 1, 0, 'h25, 2);
    for (int k = 0; k < 17; k++) rd(0, 3, 6'b000001, 1);
    chk_all("saturate", 1, 0, 'h25, 'hF);
    wr(7, 15, 6'b000000);
    blk = 7; ac = 15; rd_en = 1;
    tick();
    rd_en = 0; par = 6'b000001; clr = 1;
    tick();
    par = 0; clr = 0;
    chk_all("clr_and_err", 1, 1, 'h7F, 1);
    rst = 1;
    tick();
    rst = 0;
    chk_all("reset2", 0, 0, 0, 0);
    rd(1, 1, 6'b000001, 1);
    chk_all("unwritten", 0, 0, 0, 0);
    rd(2, 5, 6'b000011, 1);
    chk_all("valid_cleared", 0, 0, 0, 0);
    wr(2, 5, 6'b000000);
    blk = 2; ac = 5; rd_en = 1;
    tick();
    rd_en = 0; par = 6'b000001; rst = 1;
    tick();
    rst = 0;
    tick();
    par = 0;
    chk_all("reset_s1", 0, 0, 0, 0);
    wr(4, 4, 6'b000000);
    rd(4, 4, 6'b000001, 0);
    chk_all("chk_dis", 0, 0, 0, 0);
    wr(3, 3, 6'b000000);
    blk = 3; ac = 3; par = 6'b000001; wr_en = 1; rd_en = 1;
    tick();
    wr_en = 0; rd_en = 0;
    tick();
    par = 0;
    chk_all("write_wins", 0, 0, 0, 0);
    wr(3, 1, 6'b000001);
    wr(3, 2, 6'b000011);
    blk = 3; ac = 1; rd_en = 1;
    tick();
    ac = 2; par = 6'b000001;
    tick();
    rd_en = 0;
    chk_all("b2b_a", 0, 0, 0, 0);
    tick();
    par = 0;
    chk_all("b2b_b", 1, 1, 'h32, 1);
    clr = 1;
    tick();
    clr = 0;
    chk_all("clear", 0, 0, 0, 0);
`ifdef FM_PAR_INJECT_EN
    inj = 1;
    wr(1, 0, 6'b000000);
    inj = 0;
    rd(1, 0, 6'b000000, 1);
    chk_all("inject", 1, 1, 'h10, 1);
    clr = 1;
    tick();
    clr = 0;
    rd(1, 0, 6'b000000, 0);
    chk_all("inject_dis", 0, 0, 0, 0);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
